mpu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the configurable multi-function multiply unit (32x32 multiply, 4-lane 8-bit dot product, 16-bit complex multiply). It accepts operation requests on valid/ready ports and grants one per cycle round-robin. It drives the unit's op/ctrl/ww/A/B inputs from registers and tracks each issued operation through the unit's fixed pipeline latency. It returns each result, with an error flag, to the requester that issued it.

---
 rtl/mpu_pkg.sv | 31 +++
 rtl/mpu_arbiter_rr.sv | 34 +++
 rtl/mpu_arbiter.sv | 148 ++++++++++++++
 tb/tb_mpu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared encodings, tag bundle and legality check
// for the multiply-unit arbiter slice.
package mpu_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_DOT  = 3'b010;
  localparam logic [2:0] OP_CPX  = 3'b100;

  localparam logic [1:0] CTRL_CPX_A = 2'b01;
  localparam logic [1:0] CTRL_CPX_B = 2'b10;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

  function automatic logic op_legal(
    input logic [2:0] op,
    input logic [1:0] ctrl
  );
    logic cpx_ok;
    cpx_ok = (ctrl == CTRL_CPX_A) ||
             (ctrl == CTRL_CPX_B);
    return (op == OP_MUL) ||
           (op == OP_DOT) ||
           ((op == OP_CPX) && cpx_ok);
  endfunction

endpackage

// File: rtl/mpu_arbiter_rr.sv
// mpu_rr_arb: two-way round-robin grant.
// rr_last remembers the most recent winner.
module mpu_rr_arb (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_last;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11):
        grant = rr_last ? 2'b01 : 2'b10;
      (valid == 2'b01):
        grant = 2'b01;
      (valid == 2'b10):
        grant = 2'b10;
      default:
        grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_last <= 1'b1;
    end else if (|grant) begin
      rr_last <= grant[1];
    end
  end

endmodule

// File: rtl/mpu_arbiter.sv
// mpu_arbiter: two-port front end for the multi-function
// multiply unit; in-order tagged result return.
module mpu_arbiter
  import mpu_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [1:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [1:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic [63:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [63:0] rsp1_data,
  output logic        rsp1_err,
  output logic [2:0]  mu_op,
  output logic [1:0]  mu_ctrl,
  output logic [1:0]  mu_ww,
  output logic [31:0] mu_a,
  output logic [31:0] mu_b,
  input  logic [63:0] mu_mout,
  output logic        busy
);

  logic [1:0]  grant;
  logic        accept;
  logic        gid;
  logic        legal;
  logic [2:0]  sel_op;
  logic [1:0]  sel_ctrl;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  tag_t        tag_q [LAT+1];
  tag_t        tag_last;
  logic [63:0] rsp_word;

  mpu_rr_arb u_arb (
    .clk   (clk),
    .n_rst (n_rst),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign gid        = grant[1];

  always_comb begin
    sel_op   = req0_op;
    sel_ctrl = req0_ctrl;
    sel_a    = req0_a;
    sel_b    = req0_b;
    if (gid) begin
      sel_op   = req1_op;
      sel_ctrl = req1_ctrl;
      sel_a    = req1_a;
      sel_b    = req1_b;
    end
  end

  assign legal = op_legal(sel_op, sel_ctrl);
  assign mu_ww = 2'b00;

  // Illegal or idle cycles feed the unit a harmless no-op.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mu_op   <= OP_NONE;
      mu_ctrl <= 2'b00;
      mu_a    <= '0;
      mu_b    <= '0;
    end else if (accept && legal) begin
      mu_op   <= sel_op;
      mu_ctrl <= sel_ctrl;
      mu_a    <= sel_a;
      mu_b    <= sel_b;
    end else begin
      mu_op   <= OP_NONE;
      mu_ctrl <= 2'b00;
      mu_a    <= '0;
      mu_b    <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{
        valid: accept,
        id:    gid,
        err:   accept && !legal
      };
      for (int i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_last = tag_q[LAT];
  assign rsp_word = tag_last.err ? '0 : mu_mout;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (tag_last.valid && !tag_last.id) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= rsp_word;
        rsp0_err   <= tag_last.err;
      end
      if (tag_last.valid && tag_last.id) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= rsp_word;
        rsp1_err   <= tag_last.err;
      end
    end
  end

endmodule

// File: tb/tb_mpu_arbiter.sv
// tb_mpu_arbiter: directed bench with a queue-based model
// of grant/return behaviour and a model of the multiply unit.
module tb_mpu_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [1:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [63:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [2:0]  mu_op;
  logic [1:0]  mu_ctrl, mu_ww;
  logic [31:0] mu_a, mu_b;
  logic [63:0] mu_mout;
  logic        busy;

  always #5 clk = ~clk;

  mpu_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .mu_op(mu_op), .mu_ctrl(mu_ctrl), .mu_ww(mu_ww),
    .mu_a(mu_a), .mu_b(mu_b), .mu_mout(mu_mout),
    .busy(busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // Arithmetic of the multiply unit itself.
  function automatic logic [63:0] unit_f(
    input logic [2:0] op, input logic [1:0] ctrl,
    input logic [31:0] a, input logic [31:0] b);
    int acc;
    logic signed [31:0] ar, ai, br, bi, re, im;
    ar = {{16{a[15]}}, a[15:0]};
    ai = {{16{a[31]}}, a[31:16]};
    br = {{16{b[15]}}, b[15:0]};
    bi = {{16{b[31]}}, b[31:16]};
    case (op)
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b010: begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += int'($signed(a[8*k+:8])) *
                 int'($signed(b[8*k+:8]));
        return {{32{acc[31]}}, acc};
      end
      3'b100: begin
        if (ctrl == 2'b10) begin
          re = ar * br + ai * bi;
          im = ai * br - ar * bi;
        end else begin
          re = ar * br - ai * bi;
          im = ar * bi + ai * br;
        end
        return {im, re};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [63:0] upipe [LAT];
  always @(posedge clk) begin
    upipe[0] <= unit_f(mu_op, mu_ctrl, mu_a, mu_b);
    for (int k = 1; k < LAT; k++) upipe[k] <= upipe[k-1];
  end
  assign mu_mout = upipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        id;
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic        last_gnt = 1'b1;
  logic [63:0] hold0 = '0, hold1 = '0;
  logic        herr0 = 1'b0, herr1 = 1'b0;
  logic [2:0]  e_op = '0;
  logic [1:0]  e_ctrl = '0;
  logic [31:0] e_a = '0, e_b = '0;
  logic        x0, x1, bx, gv, g, lg;
  logic [2:0]  p_op;
  logic [1:0]  p_ctrl;
  logic [31:0] p_a, p_b;

  int          n_obs = 0, n_acc = 0;
  logic        obs_port [16];
  logic [63:0] obs_data [16];
  logic        obs_err  [16];
  int          obs_cyc  [16];
  logic        acc_port [16];
  int          acc_cyc  [16];

  always @(negedge clk) begin
    if (rsp0_valid && n_obs < 16) begin
      obs_port[n_obs] = 1'b0; obs_data[n_obs] = rsp0_data;
      obs_err[n_obs] = rsp0_err; obs_cyc[n_obs] = cyc;
      n_obs++;
    end
    if (rsp1_valid && n_obs < 16) begin
      obs_port[n_obs] = 1'b1; obs_data[n_obs] = rsp1_data;
      obs_err[n_obs] = rsp1_err; obs_cyc[n_obs] = cyc;
      n_obs++;
    end
    if (!n_rst) begin
      q.delete();
      last_gnt = 1'b1;
      hold0 = '0; hold1 = '0; herr0 = 0; herr1 = 0;
      e_op = '0; e_ctrl = '0; e_a = '0; e_b = '0;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_rsp_err", {rsp0_err, rsp1_err}, 0);
      chk("rst_rsp0_data", rsp0_data, 0);
      chk("rst_rsp1_data", rsp1_data, 0);
      chk("rst_mu_ctl", {mu_op, mu_ctrl, mu_ww}, 0);
      chk("rst_mu_ab", {mu_a, mu_b}, 0);
    end else begin
      x0 = 0; x1 = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.id) begin
          x1 = 1; hold1 = e.data; herr1 = e.err;
        end else begin
          x0 = 1; hold0 = e.data; herr0 = e.err;
        end
      end
      bx = 0;
      foreach (q[k]) if (q[k].due - LAT - 1 <= cyc) bx = 1;
      chk("rsp0_valid", 64'(rsp0_valid), 64'(x0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(x1));
      chk("rsp0_data", rsp0_data, hold0);
      chk("rsp1_data", rsp1_data, hold1);
      chk("rsp_err", {rsp0_err, rsp1_err}, {herr0, herr1});
      chk("busy", 64'(busy), 64'(bx));
      chk("mu_ctl", {mu_op, mu_ctrl, mu_ww},
          {e_op, e_ctrl, 2'b00});
      chk("mu_ab", {mu_a, mu_b}, {e_a, e_b});
      gv = req0_valid | req1_valid;
      if (req0_valid && req1_valid) g = ~last_gnt;
      else g = req1_valid;
      chk("ready", {req0_ready, req1_ready},
          {gv && !g, gv && g});
      e_op = '0; e_ctrl = '0; e_a = '0; e_b = '0;
      if (gv) begin
        last_gnt = g;
        p_op = g ? req1_op : req0_op;
        p_ctrl = g ? req1_ctrl : req0_ctrl;
        p_a = g ? req1_a : req0_a;
        p_b = g ? req1_b : req0_b;
        lg = (p_op == 3'b001) || (p_op == 3'b010) ||
             (p_op == 3'b100 &&
              (p_ctrl == 2'b01 || p_ctrl == 2'b10));
        e.due = cyc + LAT + 2;
        e.id = g;
        e.err = !lg;
        e.data = lg ? unit_f(p_op, p_ctrl, p_a, p_b) : 0;
        q.push_back(e);
        if (lg) begin
          e_op = p_op; e_ctrl = p_ctrl; e_a = p_a; e_b = p_b;
        end
        if (n_acc < 16) begin
          acc_port[n_acc] = g; acc_cyc[n_acc] = cyc + 1;
          n_acc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic set0(input logic [2:0] op,
                      input logic [1:0] c,
                      input logic [31:0] a,
                      input logic [31:0] b);
    req0_valid = 1; req0_op = op; req0_ctrl = c;
    req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic [2:0] op,
                      input logic [1:0] c,
                      input logic [31:0] a,
                      input logic [31:0] b);
    req1_valid = 1; req1_op = op; req1_ctrl = c;
    req1_a = a; req1_b = b;
  endtask

  task automatic clr_logs();
    n_obs = 0; n_acc = 0;
  endtask

  localparam logic [63:0] CPX_RES = 64'h01026000_fffcc000;
  logic lit_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    idle();
    req0_op = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0;
    req1_op = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0;
    repeat (3) step();
    chk("reset_busy", 64'(busy), 0);
    chk("reset_mu_op", 64'(mu_op), 0);
    n_rst = 1;

    // single multiply
    clr_logs();
    set0(3'b001, 2'b00, 32'h1ff, 32'h1ff);
    step(); idle();
    repeat (6) step();
    chk("mul_count", 64'(n_obs), 1);
    chk("mul_port", 64'(obs_port[0]), 0);
    chk("mul_data", obs_data[0], 64'h3fc01);
    chk("mul_err", 64'(obs_err[0]), 0);
    chk("mul_lat", 64'(obs_cyc[0] - acc_cyc[0]), 3);

    // dot product on port 1
    clr_logs();
    set1(3'b010, 2'b00, 32'h12030421, 32'h421156f1);
    step(); idle();
    repeat (6) step();
    chk("dot_count", 64'(n_obs), 1);
    chk("dot_port", 64'(obs_port[0]), 1);
    chk("dot_data", obs_data[0], 64'h440);

    // contention, four complex ops
    clr_logs();
    set0(3'b100, 2'b01, 32'h0200f000, 32'hf0200230);
    set1(3'b100, 2'b01, 32'h0200f000, 32'hf0200230);
    repeat (4) step();
    idle();
    repeat (8) step();
    chk("cpx_acc_count", 64'(n_acc), 4);
    chk("cpx_rsp_count", 64'(n_obs), 4);
    for (int k = 0; k < 4; k++) begin
      chk("cpx_grant", 64'(acc_port[k]), 64'(lit_port[k]));
      chk("cpx_port", 64'(obs_port[k]), 64'(lit_port[k]));
      chk("cpx_data", obs_data[k], CPX_RES);
      chk("cpx_b2b", 64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
    end
    chk("cpx_lat", 64'(obs_cyc[0] - acc_cyc[0]), 3);

    // illegal ops followed by a legal one
    clr_logs();
    set0(3'b011, 2'b00, 32'h7, 32'h9);
    step();
    chk("ill1_mu_op", 64'(mu_op), 0);
    set0(3'b100, 2'b11, 32'h7, 32'h9);
    step();
    chk("ill2_mu_op", 64'(mu_op), 0);
    set0(3'b001, 2'b00, 32'd3, 32'd5);
    step(); idle();
    chk("legal_mu_op", 64'(mu_op), 64'(3'b001));
    repeat (6) step();
    chk("ill_count", 64'(n_obs), 3);
    chk("ill_errs", {obs_err[0], obs_err[1], obs_err[2]},
        64'(3'b110));
    chk("ill1_data", obs_data[0], 0);
    chk("ill2_data", obs_data[1], 0);
    chk("ill_next_data", obs_data[2], 64'd15);
    chk("ill_lat", 64'(obs_cyc[0] - acc_cyc[0]), 3);
    chk("ill_order", 64'(obs_cyc[2] - obs_cyc[0]), 2);

    // reset while two ops are in flight
    clr_logs();
    set0(3'b001, 2'b00, 32'd2, 32'd3);
    step(); idle();
    set1(3'b001, 2'b00, 32'd4, 32'd5);
    step(); idle();
    step();
    chk("mid_busy", 64'(busy), 1);
    n_rst = 0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
    repeat (3) step();
    chk("mid_discard", 64'(n_obs), 0);
    clr_logs();
    set0(3'b001, 2'b00, 32'd2, 32'd3);
    set1(3'b001, 2'b00, 32'd4, 32'd5);
    n_rst = 1;
    #1;
    chk("post_rst_grant", {req0_ready, req1_ready},
        64'(2'b10));
    step();
    chk("post_rst_next", {req0_ready, req1_ready},
        64'(2'b01));
    step(); idle();
    repeat (6) step();
    chk("post_count", 64'(n_obs), 2);
    chk("post_port0", 64'(obs_port[0]), 0);
    chk("post_data0", obs_data[0], 64'd6);
    chk("post_port1", 64'(obs_port[1]), 1);
    chk("post_data1", obs_data[1], 64'd20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
